// File: rtl/addrc_controller.sv
// Batch sequencer for the addRC line store: loads each file, streams its 64 lines
// downstream under a valid/ready handshake, and steps file and Keccak round indices.
module addrc_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] base_index,
    input  logic [9:0] num_files,
    input  logic       out_ready,
    output logic       read_file,
    output logic [9:0] file_index,
    output logic [5:0] line_index,
    output logic [4:0] round_index,
    output logic       out_valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WAIT   = 3'd2,
        S_STREAM = 3'd3,
        S_NEXT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [5:0] LAST_LINE  = 6'd63;
    localparam logic [4:0] LAST_ROUND = 5'd23;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [9:0] r_base;
    logic [9:0] r_num;
    logic [9:0] r_file_cnt;
    logic [9:0] w_file_cnt_inc;
    logic [9:0] r_file_index;
    logic [5:0] r_line_index;
    logic [4:0] r_round_index;
    logic       r_read_file;
    logic       r_out_valid;
    logic       r_busy;
    logic       r_done;

    // Keccak has 24 rounds per permutation, so the round tag cycles 0..23.
    function automatic logic [4:0] f_round_inc(input logic [4:0] round_i);
        if (round_i == LAST_ROUND) begin
            return 5'd0;
        end else begin
            return round_i + 5'd1;
        end
    endfunction

    assign w_file_cnt_inc = r_file_cnt + 10'd1;

    // Next-state selection for the batch sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (num_files != 10'd0) begin
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD:   w_state_nxt = S_WAIT;
            S_WAIT:   w_state_nxt = S_STREAM;
            S_STREAM: begin
                if (out_ready && (r_line_index == LAST_LINE)) begin
                    w_state_nxt = S_NEXT;
                end else begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_NEXT: begin
                if (w_file_cnt_inc == r_num) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // State register plus strobes decoded from the next state so they are flop outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_read_file <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_read_file <= (w_state_nxt == S_LOAD);
            r_out_valid <= (w_state_nxt == S_STREAM);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    // Batch parameters and the file/line/round address counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_base        <= 10'd0;
            r_num         <= 10'd0;
            r_file_cnt    <= 10'd0;
            r_file_index  <= 10'd0;
            r_line_index  <= 6'd0;
            r_round_index <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (num_files != 10'd0)) begin
                        r_base        <= base_index;
                        r_num         <= num_files;
                        r_file_cnt    <= 10'd0;
                        r_file_index  <= base_index;
                        r_line_index  <= 6'd0;
                        r_round_index <= 5'd0;
                    end
                end
                S_STREAM: begin
                    // Line counter wraps 63 -> 0 naturally, ready for the next file.
                    if (out_ready) begin
                        r_line_index <= r_line_index + 6'd1;
                    end
                end
                S_NEXT: begin
                    r_file_cnt    <= w_file_cnt_inc;
                    r_file_index  <= r_file_index + 10'd1;
                    r_round_index <= f_round_inc(r_round_index);
                end
                default: begin
                end
            endcase
        end
    end

    assign read_file   = r_read_file;
    assign file_index  = r_file_index;
    assign line_index  = r_line_index;
    assign round_index = r_round_index;
    assign out_valid   = r_out_valid;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_addrc_controller.sv
// Scoreboard bench for addrc_controller: expected loads/lines are queued per batch
// from index arithmetic; a negedge monitor pops and compares what the DUT presents.
module tb_addrc_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [9:0] base_index = 10'd0;
    logic [9:0] num_files = 10'd0;
    logic       out_ready = 1'b0;
    logic       read_file;
    logic [9:0] file_index;
    logic [5:0] line_index;
    logic [4:0] round_index;
    logic       out_valid;
    logic       busy;
    logic       done;

    addrc_controller dut (
        .clk(clk), .rst(rst), .start(start), .base_index(base_index),
        .num_files(num_files), .out_ready(out_ready), .read_file(read_file),
        .file_index(file_index), .line_index(line_index), .round_index(round_index),
        .out_valid(out_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [20:0] q_line[$];   // {file, round, line}
    logic [14:0] q_load[$];   // {file, round}
    int rf_stamps[$];
    int valid_stamps[$];
    int done_stamp = -1;
    int done_seen = 0;
    int exp_done = 0;
    int busy_cnt = 0;
    int ready_pct = 100;
    bit stray = 1'b0;

    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [5:0] prev_line = 6'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: outputs sampled at negedge, inputs are those for the coming edge
    always @(negedge clk) begin
        if (rst) begin
            chk("valid_and_load_exclusive", {31'd0, out_valid & read_file}, 32'd0);
            if (read_file || out_valid || done) chk("busy_when_active", {31'd0, busy}, 32'd1);
            if (busy) busy_cnt++;
            if (read_file) begin
                rf_stamps.push_back(cyc);
                if (q_load.size() == 0) begin
                    chk("unexpected_load", {31'd0, read_file}, 32'd0);
                end else begin
                    chk("load_file_round", {17'd0, file_index, round_index}, {17'd0, q_load.pop_front()});
                    chk("load_line_zero", {26'd0, line_index}, 32'd0);
                end
            end
            if (out_valid && !prev_valid) valid_stamps.push_back(cyc);
            if (prev_valid && !prev_ready && out_valid)
                chk("line_hold", {26'd0, line_index}, {26'd0, prev_line});
            if (out_valid && out_ready) begin
                if (q_line.size() == 0) begin
                    chk("unexpected_line", {31'd0, out_valid}, 32'd0);
                end else begin
                    chk("stream_word", {11'd0, file_index, round_index, line_index},
                        {11'd0, q_line.pop_front()});
                end
            end
            if (done) begin
                done_seen++;
                done_stamp = cyc;
                chk("done_lines_left", q_line.size(), 32'd0);
                chk("done_loads_left", q_load.size(), 32'd0);
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_line  = line_index;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Queue the reference behaviour for a batch and pulse start; returns the start cycle.
    task automatic issue(input int b, input int n, output int s);
        rf_stamps.delete();
        valid_stamps.delete();
        done_stamp = -1;
        for (int f = 0; f < n; f++) begin
            q_load.push_back({10'((b + f) % 1024), 5'(f % 24)});
            for (int l = 0; l < 64; l++)
                q_line.push_back({10'((b + f) % 1024), 5'(f % 24), 6'(l)});
        end
        exp_done++;
        start      = 1'b1;
        base_index = 10'(b);
        num_files  = 10'(n);
        s = cyc;
        tick();
        start      = 1'b0;
        base_index = 10'($urandom);
        num_files  = 10'($urandom);
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (done_seen < exp_done && k < budget) begin
            out_ready = ($urandom_range(99) < ready_pct);
            if (stray && $urandom_range(7) == 0) begin
                start      = 1'b1;
                base_index = 10'($urandom);
                num_files  = 10'($urandom_range(1, 5));
            end else begin
                start = 1'b0;
            end
            tick();
            k++;
        end
        start = 1'b0;
        chk(name, done_seen, exp_done);
    endtask

    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int k;
        int seen_before;
        @(posedge clk);
        #2;
        // reset state, with start presented during reset
        start = 1'b1; base_index = 10'd55; num_files = 10'd4;
        repeat (3) tick();
        chk("rst_read_file", {31'd0, read_file}, 32'd0);
        chk("rst_file_index", {22'd0, file_index}, 32'd0);
        chk("rst_line_index", {26'd0, line_index}, 32'd0);
        chk("rst_round_index", {27'd0, round_index}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b1; start = 1'b0;
        tick();
        chk("start_during_rst_ignored", {31'd0, busy}, 32'd0);

        // two files, ready tied high: exact timing
        ready_pct = 100; out_ready = 1'b1;
        issue(5, 2, s);
        wait_done("two_file_done", 400);
        chk("two_file_loads", rf_stamps.size(), 32'd2);
        if (rf_stamps.size() == 2) begin
            chk("load0_cycle", rf_stamps[0] - s, 32'd1);
            chk("load1_cycle", rf_stamps[1] - s, 32'd68);
        end
        if (valid_stamps.size() > 0) chk("first_valid_latency", valid_stamps[0] - s, 32'd3);
        else chk("first_valid_seen", valid_stamps.size(), 32'd1);
        chk("done_cycle", done_stamp - s, 32'd135);
        tick();

        // empty batch
        busy_cnt = 0;
        issue(12, 0, s);
        wait_done("empty_done", 10);
        repeat (2) tick();
        chk("empty_no_load", rf_stamps.size(), 32'd0);
        chk("empty_no_valid", valid_stamps.size(), 32'd0);
        chk("empty_done_cycle", done_stamp - s, 32'd1);
        chk("empty_busy_cycles", busy_cnt, 32'd1);

        // ready pattern 1,0,0,1 at start of stream
        out_ready = 1'b0;
        issue(100, 1, s);
        k = 0;
        while (!out_valid && k < 10) begin tick(); k++; end
        chk("reach_stream", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            out_ready = pat[i];
            tick();
        end
        chk("pattern_line", {26'd0, line_index}, 32'd2);
        ready_pct = 100;
        wait_done("pattern_done", 200);
        tick();

        // index wrap: 1023 -> 0, round 23 -> 0
        issue(1023, 26, s);
        wait_done("wrap_done", 2000);
        chk("wrap_loads", rf_stamps.size(), 32'd26);
        tick();

        // reset in mid-stream at line 40
        out_ready = 1'b1;
        issue(7, 1, s);
        k = 0;
        while (line_index != 6'd40 && k < 100) begin tick(); k++; end
        chk("reach_line40", {26'd0, line_index}, 32'd40);
        seen_before = done_seen;
        rst = 1'b0;
        q_line.delete();
        q_load.delete();
        exp_done--;
        tick();
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_line", {26'd0, line_index}, 32'd0);
        chk("abort_file", {22'd0, file_index}, 32'd0);
        chk("abort_round", {27'd0, round_index}, 32'd0);
        rst = 1'b1;
        repeat (3) tick();
        chk("abort_no_done", done_seen, seen_before);
        issue(9, 1, s);
        wait_done("post_abort_done", 200);
        tick();

        // stray start pulses during the batch are ignored
        stray = 1'b1; ready_pct = 70;
        issue(200, 2, s);
        wait_done("stray_done", 1000);
        stray = 1'b0;
        tick();

        // randomized batches
        for (int t = 0; t < 8; t++) begin
            ready_pct = $urandom_range(30, 100);
            stray = $urandom_range(1);
            issue($urandom_range(1023), $urandom_range(1, 3), s);
            wait_done("rand_done", 4000);
            stray = 1'b0;
            start = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end

        chk("final_lines_empty", q_line.size(), 32'd0);
        chk("final_loads_empty", q_load.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
